events_to_apb_rr: RTL and testbench

Parametrised event-to-APB bridge. Counts pulses on `NUM_EVENTS` independent event inputs and reports each channel's accumulated count as an APB write to a per-channel address. It arbitrates between channels round-robin and supports back-to-back transfers. It sits between event sources, such as interrupt or status pulse generators, and an APB completer such as a logging or status register block.

---
 rtl/events_to_apb_rr.sv | 157 +++++++++++++++
 tb/tb_events_to_apb_rr.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/events_to_apb_rr.sv
// rtl/events_to_apb_rr.sv - round-robin event counter bridge reporting counts as APB writes
// Optional feature macro: EVENTS_TO_APB_SLVERR_RETRY_EN (retry an errored transfer on the same channel)
module events_to_apb_rr #(
    parameter int          NUM_EVENTS  = 4,
    parameter int          CNT_W       = 8,
    parameter logic [31:0] ADDR_BASE   = 32'hABBA_0000,
    parameter logic [31:0] ADDR_STRIDE = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic                  apb_psel_o,
    output logic                  apb_penable_o,
    output logic [31:0]           apb_paddr_o,
    output logic                  apb_pwrite_o,
    output logic [31:0]           apb_pwdata_o,
    input  logic                  apb_pready_i,
    input  logic                  apb_pslverr_i
);

    localparam int IDX_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q [NUM_EVENTS];
    logic [IDX_W-1:0]       last_q;
    logic                   psel_q, penable_q;
    logic [31:0]            paddr_q, pwdata_q;

    logic [NUM_EVENTS-1:0]  pending;
    logic                   any_pending;
    logic [IDX_W-1:0]       grant_idx, sel_idx;
    logic                   grant, retry;
    logic [CNT_W-1:0]       sel_val;

    // Three-operand add clamped to the counter maximum; counters never wrap
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b,
                                                 input logic c);
        logic [CNT_W+1:0] s;
        s = {2'b00, a} + {2'b00, b} + {{(CNT_W+1){1'b0}}, c};
        return (s > {2'b00, CNT_MAX}) ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    // A channel has work if it holds a count or is pulsing this cycle
    always_comb begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
            pending[i] = (cnt_q[i] != '0) || event_i[i];
        end
        any_pending = |pending;
    end

    // Round-robin pick: first pending channel after the last one served
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] c;
        found     = 1'b0;
        c         = '0;
        grant_idx = last_q;
        for (int k = 1; k <= NUM_EVENTS; k++) begin
            c = IDX_W'((int'(last_q) + k) % NUM_EVENTS);
            if (!found && pending[c]) begin
                found     = 1'b1;
                grant_idx = c;
            end
        end
    end

    // Next-state logic; a grant happens on leaving IDLE or on a completed ACCESS
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        retry   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    grant   = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (apb_pready_i) begin
`ifdef EVENTS_TO_APB_SLVERR_RETRY_EN
                    if (apb_pslverr_i) begin
                        retry   = 1'b1;
                        state_d = SETUP;
                    end else
`endif
                    if (any_pending) begin
                        grant   = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A retry re-serves the channel just reported, which is always last_q
    always_comb begin
        sel_idx = retry ? last_q : grant_idx;
        if (retry) begin
            sel_val = sat_add(pwdata_q[CNT_W-1:0], cnt_q[sel_idx], event_i[sel_idx]);
        end else begin
            sel_val = sat_add(cnt_q[sel_idx], '0, event_i[sel_idx]);
        end
    end

`ifndef EVENTS_TO_APB_SLVERR_RETRY_EN
    logic unused_pslverr;
    assign unused_pslverr = apb_pslverr_i;
`endif

    // State, counters and registered APB outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= IDX_W'(NUM_EVENTS - 1);
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= (state_d != IDLE);
            penable_q <= (state_d == ACCESS);
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if ((grant || retry) && (IDX_W'(i) == sel_idx)) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= sat_add(cnt_q[i], '0, event_i[i]);
                end
            end
            if (grant) last_q <= grant_idx;
            if (grant || retry) begin
                paddr_q  <= ADDR_BASE + 32'(sel_idx) * ADDR_STRIDE;
                pwdata_q <= 32'(sel_val);
            end else if (state_d == IDLE) begin
                paddr_q  <= '0;
                pwdata_q <= '0;
            end
        end
    end

    assign apb_psel_o    = psel_q;
    assign apb_penable_o = penable_q;
    assign apb_pwrite_o  = psel_q;
    assign apb_paddr_o   = paddr_q;
    assign apb_pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_events_to_apb_rr.sv
// tb/tb_events_to_apb_rr.sv - self-checking bench for events_to_apb_rr
module tb_events_to_apb_rr;

    localparam int          NE     = 4;
    localparam int          CMAX   = 255;
    localparam logic [31:0] BASE   = 32'hABBA_0000;
    localparam logic [31:0] STRIDE = 32'h0001_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [NE-1:0] event_i;
    logic          apb_psel_o, apb_penable_o, apb_pwrite_o;
    logic [31:0]   apb_paddr_o, apb_pwdata_o;
    logic          apb_pready_i, apb_pslverr_i;

    events_to_apb_rr #(.NUM_EVENTS(NE), .CNT_W(8), .ADDR_BASE(BASE), .ADDR_STRIDE(STRIDE)) dut (
        .clk(clk), .reset(reset), .event_i(event_i),
        .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o), .apb_paddr_o(apb_paddr_o),
        .apb_pwrite_o(apb_pwrite_o), .apb_pwdata_o(apb_pwdata_o),
        .apb_pready_i(apb_pready_i), .apb_pslverr_i(apb_pslverr_i)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: transfer-level view with plain integer counts
    int mcnt[NE];
    int mlast;
    int mphase;      // 0 none, 1 address phase, 2 data phase
    int m_addr, m_data;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) mcnt[i] = 0;
        mlast  = NE - 1;
        mphase = 0;
        m_addr = 0;
        m_data = 0;
    endtask

    task automatic model_step(input logic [NE-1:0] ev, input logic rdy, input logic err);
        int  g;
        bit  retry_now;
        g = -1;
        retry_now = 0;
        if (mphase == 0 || (mphase == 2 && rdy)) begin
`ifdef EVENTS_TO_APB_SLVERR_RETRY_EN
            if (mphase == 2 && err) retry_now = 1;
`endif
            if (retry_now) begin
                g = mlast;
                m_data = sat(m_data + mcnt[g] + int'(ev[g]));
            end else begin
                for (int k = 1; k <= NE; k++) begin
                    int c;
                    c = (mlast + k) % NE;
                    if (g < 0 && (mcnt[c] != 0 || ev[c])) g = c;
                end
                if (g >= 0) begin
                    m_addr = int'(BASE) + g * int'(STRIDE);
                    m_data = sat(mcnt[g] + int'(ev[g]));
                    mlast  = g;
                end
            end
            mphase = (g >= 0) ? 1 : 0;
        end else if (mphase == 1) begin
            mphase = 2;
        end
        for (int i = 0; i < NE; i++) begin
            if (i == g) mcnt[i] = 0;
            else        mcnt[i] = sat(mcnt[i] + int'(ev[i]));
        end
    endtask

    task automatic check_all(input string tag);
        logic busy;
        busy = (mphase != 0);
        chk({tag, ".psel"},    32'(apb_psel_o),    32'(busy));
        chk({tag, ".penable"}, 32'(apb_penable_o), 32'(mphase == 2));
        chk({tag, ".pwrite"},  32'(apb_pwrite_o),  32'(busy));
        chk({tag, ".paddr"},   apb_paddr_o,        busy ? 32'(m_addr) : 32'h0);
        chk({tag, ".pwdata"},  apb_pwdata_o,       busy ? 32'(m_data) : 32'h0);
    endtask

    task automatic cycle(input logic [NE-1:0] ev, input logic rdy, input logic err);
        event_i       = ev;
        apb_pready_i  = rdy;
        apb_pslverr_i = err;
        @(posedge clk);
        model_step(ev, rdy, err);
        #1;
        check_all("model");
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, ".psel"},    32'(apb_psel_o),    32'h0);
        chk({tag, ".penable"}, 32'(apb_penable_o), 32'h0);
        chk({tag, ".paddr"},   apb_paddr_o,        32'h0);
        chk({tag, ".pwdata"},  apb_pwdata_o,       32'h0);
    endtask

    task automatic hard_reset();
        event_i = '0; apb_pready_i = 1'b1; apb_pslverr_i = 1'b0;
        reset = 1'b1;
        #1;
        check_zero_outputs("reset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_addr [3];
        logic [NE-1:0] ev;
        exp_addr[0] = 32'hABBA_0000;
        exp_addr[1] = 32'hABBB_0000;
        exp_addr[2] = 32'hABBD_0000;

        reset = 1'b1; event_i = '0; apb_pready_i = 1'b1; apb_pslverr_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("por");
        reset = 1'b0;

        // Single pulse on channel 2
        cycle(4'b0100, 1'b1, 1'b0);
        chk("single.psel",  32'(apb_psel_o), 32'h1);
        chk("single.paddr", apb_paddr_o,     32'hABBC_0000);
        chk("single.data",  apb_pwdata_o,    32'h1);
        cycle(4'b0000, 1'b1, 1'b0);
        chk("single.penable", 32'(apb_penable_o), 32'h1);
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        chk("single.idle", 32'(apb_psel_o), 32'h0);

        // Three channels at once, back-to-back service
        hard_reset();
        cycle(4'b1011, 1'b1, 1'b0);
        for (int t = 0; t < 6; t++) begin
            chk("b2b.psel", 32'(apb_psel_o), 32'h1);
            if (t % 2 == 0) begin
                chk("b2b.paddr", apb_paddr_o, exp_addr[t/2]);
                chk("b2b.data",  apb_pwdata_o, 32'h1);
            end
            cycle(4'b0000, 1'b1, 1'b0);
        end
        chk("b2b.end", 32'(apb_psel_o), 32'h0);

        // Ten pulses on channel 0 across a stalled transfer
        hard_reset();
        cycle(4'b0001, 1'b0, 1'b0);
        chk("stall.first", apb_pwdata_o, 32'h1);
        repeat (9) cycle(4'b0001, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        chk("stall.second", apb_pwdata_o, 32'h9);
        repeat (3) cycle(4'b0000, 1'b1, 1'b0);

        // Saturation on channel 1 during a long stall
        hard_reset();
        cycle(4'b0001, 1'b0, 1'b0);
        repeat (300) cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        chk("sat.paddr", apb_paddr_o, 32'hABBB_0000);
        chk("sat.data",  apb_pwdata_o, 32'd255);
        repeat (3) cycle(4'b0000, 1'b1, 1'b0);

        // Reset in the middle of ACCESS
        hard_reset();
        cycle(4'b0001, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b0);
        chk("midrst.penable", 32'(apb_penable_o), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) cycle(4'b0000, 1'b1, 1'b0);
        chk("midrst.idle", 32'(apb_psel_o), 32'h0);

        // Completer error on a channel-3 report of 5
        hard_reset();
        cycle(4'b0001, 1'b0, 1'b0);
        repeat (5) cycle(4'b1000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        chk("err.paddr", apb_paddr_o, 32'hABBD_0000);
        chk("err.data",  apb_pwdata_o, 32'd5);
        cycle(4'b1000, 1'b0, 1'b0);
        cycle(4'b1000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b1);
        chk("err.next.paddr", apb_paddr_o, 32'hABBD_0000);
`ifdef EVENTS_TO_APB_SLVERR_RETRY_EN
        chk("err.retry.data", apb_pwdata_o, 32'd7);
`else
        chk("err.next.data", apb_pwdata_o, 32'd2);
`endif
        repeat (3) cycle(4'b0000, 1'b1, 1'b0);

        // Randomized traffic against the model
        hard_reset();
        for (int n = 0; n < 800; n++) begin
            ev = '0;
            for (int i = 0; i < NE; i++) ev[i] = ($urandom_range(0, 3) == 0);
            if (n >= 400 && n < 700) ev = NE'($urandom);
            cycle(ev, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0));
        end
        repeat (20) cycle(4'b0000, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
